// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage plus IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address, and latches the
// fetched word with its PC for the decoder. The next PC follows MIPS
// delay-slot semantics: a redirect decoded in ID takes effect on the fetch
// after the delay slot.
// Optional build macro IFU_ADEL_CHECK_EN enables fetch-address fault
// detection: misaligned PC, or PC outside the instruction memory window.
// Without the macro, no check is made and fetch_exc is constant 0.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  npc_op,
  input  logic        zero,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        fetch_exc
);

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_JAL = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;

  // IF stage: program counter
  logic [31:0] pc_p0;

  // ID stage: IF/ID register contents
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic        vld_p1;
  logic        exc_p1;

  logic [31:0] pc_seq;
  logic [31:0] npc;
  logic        fault;

  // Branch target relative to the branch's own PC: the offset is a signed
  // word count, so sign-extend imm16 and scale by 4. Addition wraps mod 2^32.
  function automatic logic [31:0] beq_target(input logic [31:0] base,
                                             input logic [15:0] imm16);
    logic signed [31:0] off;
    off = {{14{imm16[15]}}, imm16, 2'b00};
    return base + 32'd4 + $unsigned(off);
  endfunction

  // Absolute jump target inside the current 256 MB region of the ID PC.
  function automatic logic [31:0] jal_target(input logic [31:0] base,
                                             input logic [25:0] idx);
    return {base[31:28], idx, 2'b00};
  endfunction

`ifdef IFU_ADEL_CHECK_EN
  // One past the last valid byte; 33 bits so a window ending at 2^32 works.
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

  // Fetch fault: misaligned PC or PC outside [IMEM_BASE, IMEM_END).
  always_comb begin
    fault = 1'b0;
    if ((pc_p0[1:0] != 2'b00) || (pc_p0 < IMEM_BASE) || ({1'b0, pc_p0} >= IMEM_END))
      fault = 1'b1;
  end
`else
  // Address checking is not built in; every fetch is accepted.
  always_comb begin
    fault = 1'b0;
  end
`endif

  // Next-PC select. The control inputs describe the ID instruction, so they
  // matter only when ID holds a real instruction. Undefined codes fall back
  // to sequential fetch.
  always_comb begin
    pc_seq = pc_p0 + 32'd4;
    npc    = pc_seq;
    if (vld_p1) begin
      case (npc_op)
        NPC_SEQ: npc = pc_seq;
        NPC_BEQ: npc = zero ? beq_target(pc_p1, imm26[15:0]) : pc_seq;
        NPC_JAL: npc = jal_target(pc_p1, imm26);
        NPC_JR:  npc = rs_data;
        default: npc = pc_seq;
      endcase
    end
  end

  // PC register: advances unless stalled. A flush without a stall still
  // advances, so the fetch stream keeps moving while ID is squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (!stall) begin
      pc_p0 <= npc;
    end
  end

  // IF/ID register: flush inserts a nop and wins over stall; a stall holds;
  // otherwise capture the fetched word. A faulting fetch is captured as an
  // invalid nop that still carries its PC for exception reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_p1 <= 32'd0;
      pc_p1    <= 32'd0;
      vld_p1   <= 1'b0;
      exc_p1   <= 1'b0;
    end else if (flush) begin
      instr_p1 <= 32'd0;
      pc_p1    <= 32'd0;
      vld_p1   <= 1'b0;
      exc_p1   <= 1'b0;
    end else if (!stall) begin
      pc_p1 <= pc_p0;
      if (fault) begin
        instr_p1 <= 32'd0;
        vld_p1   <= 1'b0;
        exc_p1   <= 1'b1;
      end else begin
        instr_p1 <= imem_rdata;
        vld_p1   <= 1'b1;
        exc_p1   <= 1'b0;
      end
    end
  end

  // Output mapping; the jal link value is derived combinationally.
  always_comb begin
    imem_addr = pc_p0;
    id_instr  = instr_p1;
    id_pc     = pc_p1;
    id_pc8    = pc_p1 + 32'd8;
    id_valid  = vld_p1;
    fetch_exc = exc_p1;
  end

endmodule
